// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch stage with decoupled fetch queue
module fetch_queue_unit #(
    parameter int                XLEN         = 64,
    parameter int                ILEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                FQ_DEPTH     = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          OUT_FE_PC_MUX,
    input  logic [XLEN-1:0]               OUT_FE_Target_Address,
    input  logic                          V_FE_BR_STALL,
    output logic                          IMEM_REQ_V,
    output logic [XLEN-1:0]               IMEM_REQ_ADDR,
    input  logic                          IMEM_REQ_RDY,
    input  logic                          IMEM_RESP_V,
    input  logic [ILEN-1:0]               IMEM_RESP_DATA,
    input  logic                          DE_RDY,
    output logic                          DE_V,
    output logic [XLEN-1:0]               DE_PC,
    output logic [XLEN-1:0]               DE_NPC,
    output logic [ILEN-1:0]               DE_IR,
    output logic [$clog2(FQ_DEPTH):0]     FQ_COUNT,
    output logic                          FE_ERR
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]     fe_pc;
    logic [XLEN-1:0]     pc_mem [FQ_DEPTH];
    logic [ILEN-1:0]     ir_mem [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] filled;
    logic [PW-1:0]       head, tail, fill_ptr;
    logic [CW-1:0]       cnt, unf_cnt, drop_cnt;
    logic                fe_err;

    logic          issue, pop, resp_drop, resp_fill, resp_err;
    logic [CW:0]   occupancy;
    logic [CW-1:0] issue_w, pop_w, fill_w, drop_w, used_w;
    logic [XLEN-1:0] tgt_aligned;

    assign occupancy   = {1'b0, cnt} + {1'b0, drop_cnt};
    assign tgt_aligned = OUT_FE_Target_Address & ~XLEN'(3);

    // Requests are withheld during reset so the port reads idle while RESET_N is low.
    assign IMEM_REQ_V    = RESET_N && !OUT_FE_PC_MUX && !V_FE_BR_STALL
                           && (occupancy < (CW+1)'(FQ_DEPTH));
    assign IMEM_REQ_ADDR = fe_pc;

    assign DE_V     = (cnt != '0) && filled[head];
    assign DE_PC    = pc_mem[head];
    assign DE_NPC   = pc_mem[head] + XLEN'(4);
    assign DE_IR    = ir_mem[head];
    assign FQ_COUNT = cnt;
    assign FE_ERR   = fe_err;

    assign issue     = IMEM_REQ_V && IMEM_REQ_RDY;
    assign pop       = DE_V && DE_RDY;
    assign resp_drop = IMEM_RESP_V && (drop_cnt != '0);
    assign resp_fill = IMEM_RESP_V && (drop_cnt == '0) && (unf_cnt != '0);
    assign resp_err  = IMEM_RESP_V && (drop_cnt == '0) && (unf_cnt == '0);

    assign issue_w = {{(CW-1){1'b0}}, issue};
    assign pop_w   = {{(CW-1){1'b0}}, pop};
    assign fill_w  = {{(CW-1){1'b0}}, resp_fill};
    assign drop_w  = {{(CW-1){1'b0}}, resp_drop};
    assign used_w  = {{(CW-1){1'b0}}, resp_drop || resp_fill};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fe_pc    <= RESET_VECTOR;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            cnt      <= '0;
            unf_cnt  <= '0;
            drop_cnt <= '0;
            filled   <= '0;
            fe_err   <= 1'b0;
        end else begin
            if (resp_err)
                fe_err <= 1'b1;
            if (OUT_FE_PC_MUX) begin
                // Every still-unfilled slot becomes a response to discard; a response
                // arriving this very cycle already consumes one of them.
                fe_pc    <= tgt_aligned;
                head     <= '0;
                tail     <= '0;
                fill_ptr <= '0;
                cnt      <= '0;
                unf_cnt  <= '0;
                filled   <= '0;
                drop_cnt <= drop_cnt + unf_cnt - used_w;
            end else begin
                if (issue) begin
                    fe_pc        <= fe_pc + XLEN'(4);
                    tail         <= tail + 1'b1;
                    filled[tail] <= 1'b0;
                end
                if (resp_fill) begin
                    fill_ptr         <= fill_ptr + 1'b1;
                    filled[fill_ptr] <= 1'b1;
                end
                if (pop)
                    head <= head + 1'b1;
                cnt      <= cnt + issue_w - pop_w;
                unf_cnt  <= unf_cnt + issue_w - fill_w;
                drop_cnt <= drop_cnt - drop_w;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (issue)
            pc_mem[tail] <= fe_pc;
        if (resp_fill && !OUT_FE_PC_MUX)
            ir_mem[fill_ptr] <= IMEM_RESP_DATA;
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             OUT_FE_PC_MUX;
    logic [XLEN-1:0]  OUT_FE_Target_Address;
    logic             V_FE_BR_STALL;
    logic             IMEM_REQ_V;
    logic [XLEN-1:0]  IMEM_REQ_ADDR;
    logic             IMEM_REQ_RDY;
    logic             IMEM_RESP_V;
    logic [ILEN-1:0]  IMEM_RESP_DATA;
    logic             DE_RDY;
    logic             DE_V;
    logic [XLEN-1:0]  DE_PC;
    logic [XLEN-1:0]  DE_NPC;
    logic [ILEN-1:0]  DE_IR;
    logic [2:0]       FQ_COUNT;
    logic             FE_ERR;

    always #5 CLK = ~CLK;

    fetch_queue_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_VECTOR('0), .FQ_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .OUT_FE_PC_MUX(OUT_FE_PC_MUX), .OUT_FE_Target_Address(OUT_FE_Target_Address),
        .V_FE_BR_STALL(V_FE_BR_STALL),
        .IMEM_REQ_V(IMEM_REQ_V), .IMEM_REQ_ADDR(IMEM_REQ_ADDR), .IMEM_REQ_RDY(IMEM_REQ_RDY),
        .IMEM_RESP_V(IMEM_RESP_V), .IMEM_RESP_DATA(IMEM_RESP_DATA),
        .DE_RDY(DE_RDY), .DE_V(DE_V), .DE_PC(DE_PC), .DE_NPC(DE_NPC), .DE_IR(DE_IR),
        .FQ_COUNT(FQ_COUNT), .FE_ERR(FE_ERR)
    );

    typedef struct { logic [63:0] pc; logic [31:0] ir; bit filled; } ent_t;
    typedef struct { logic [31:0] d; int due; } pend_t;

    int vectors = 0;
    int miscompares = 0;

    bit          mux, stall, de_rdy, req_rdy, extra;
    logic [63:0] tgt;
    int          lat = 1;
    int          cyc = 0;

    ent_t        mq[$];
    pend_t       mem[$];
    logic [63:0] m_pc;
    int          m_drop;
    bit          m_err;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] instr(logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        mq.delete();
        mem.delete();
        m_pc = '0;
        m_drop = 0;
        m_err = 0;
    endtask

    task automatic step();
        bit          rv, e_req, e_dev, used;
        logic [31:0] rd;
        int          unf, fidx;
        pend_t       p;
        ent_t        e;
        rv = 0;
        rd = '0;
        if (extra) begin
            rv = 1;
            rd = 32'hDEAD_BEEF;
        end else if (mem.size() > 0 && mem[0].due <= cyc) begin
            rv = 1;
            rd = mem[0].d;
            mem.delete(0);
        end
        OUT_FE_PC_MUX = mux;
        OUT_FE_Target_Address = tgt;
        V_FE_BR_STALL = stall;
        DE_RDY = de_rdy;
        IMEM_REQ_RDY = req_rdy;
        IMEM_RESP_V = rv;
        IMEM_RESP_DATA = rd;
        #1;
        e_req = !mux && !stall && (mq.size() + m_drop < DEPTH);
        e_dev = mq.size() > 0 && mq[0].filled;
        chk("req_v", IMEM_REQ_V, e_req);
        chk("req_addr", IMEM_REQ_ADDR, m_pc);
        chk("de_v", DE_V, e_dev);
        chk("fq_count", FQ_COUNT, mq.size());
        chk("fe_err", FE_ERR, m_err);
        if (e_dev) begin
            chk("de_pc", DE_PC, mq[0].pc);
            chk("de_npc", DE_NPC, mq[0].pc + 64'd4);
            chk("de_ir", DE_IR, mq[0].ir);
        end
        if (e_req && req_rdy) begin
            p.d = instr(m_pc);
            p.due = cyc + lat;
            mem.push_back(p);
        end
        unf = 0;
        fidx = -1;
        foreach (mq[i]) if (!mq[i].filled) begin
            unf++;
            if (fidx < 0) fidx = i;
        end
        used = rv && (m_drop > 0 || fidx >= 0);
        if (rv && !used) m_err = 1;
        if (mux) begin
            m_drop = m_drop + unf - (used ? 1 : 0);
            mq.delete();
            m_pc = tgt & ~64'h3;
        end else begin
            if (rv && m_drop > 0) m_drop--;
            else if (rv && fidx >= 0) begin
                mq[fidx].filled = 1;
                mq[fidx].ir = rd;
            end
            if (e_dev && de_rdy) mq.delete(0);
            if (e_req && req_rdy) begin
                e.pc = m_pc;
                e.ir = '0;
                e.filled = 0;
                mq.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        bit seen;
        RESET_N = 1'b0;
        OUT_FE_PC_MUX = 0; OUT_FE_Target_Address = '0; V_FE_BR_STALL = 0;
        IMEM_REQ_RDY = 0; IMEM_RESP_V = 0; IMEM_RESP_DATA = '0; DE_RDY = 0;
        mux = 0; stall = 0; de_rdy = 1; req_rdy = 1; extra = 0; tgt = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_req_v", IMEM_REQ_V, 0);
        chk("rst_de_v", DE_V, 0);
        chk("rst_fq_count", FQ_COUNT, 0);
        chk("rst_fe_err", FE_ERR, 0);
        chk("rst_req_addr", IMEM_REQ_ADDR, 64'h0);
        RESET_N = 1'b1;

        // streaming, one-cycle memory
        run(2);
        chk("first_de_v", DE_V, 1);
        chk("first_de_pc", DE_PC, 64'h0);
        chk("first_de_npc", DE_NPC, 64'h4);
        chk("first_de_ir", DE_IR, 32'h1357_9BDF);
        run(6);

        // decode stalled until the queue fills
        do_reset();
        de_rdy = 0;
        run(8);
        chk("full_count", FQ_COUNT, 4);
        chk("full_req_v", IMEM_REQ_V, 0);
        chk("full_head_pc", DE_PC, 64'h0);
        chk("full_next_addr", IMEM_REQ_ADDR, 64'h10);
        de_rdy = 1;
        run(10);

        // redirect with responses outstanding at latency 3
        do_reset();
        lat = 3;
        run(5);
        mux = 1; tgt = 64'h1002;
        step();
        mux = 0;
        chk("redir_addr", IMEM_REQ_ADDR, 64'h1000);
        chk("redir_de_v", DE_V, 0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (DE_V) seen = 1;
        end
        chk("redir_seen", seen, 1);
        if (seen) chk("redir_first_pc", DE_PC, 64'h1000);
        chk("redir_fe_err", FE_ERR, 0);
        run(4);

        // redirect coinciding with a response and a pop
        do_reset();
        lat = 2;
        run(6);
        mux = 1; tgt = 64'h2000;
        step();
        mux = 0;
        chk("same_cyc_de_v", DE_V, 0);
        run(8);

        // branch stall window, then asynchronous reset mid-burst
        run(3);
        stall = 1;
        run(5);
        stall = 0;
        run(6);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_de_v", DE_V, 0);
        chk("arst_req_v", IMEM_REQ_V, 0);
        chk("arst_fq_count", FQ_COUNT, 0);
        chk("arst_req_addr", IMEM_REQ_ADDR, 64'h0);
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;

        // spurious response with nothing outstanding
        lat = 1;
        de_rdy = 0;
        run(3);
        req_rdy = 0;
        run(3);
        extra = 1;
        step();
        extra = 0;
        chk("err_set", FE_ERR, 1);
        chk("err_count", FQ_COUNT, 3);
        chk("err_head_pc", DE_PC, 64'h0);
        de_rdy = 1;
        run(4);
        chk("err_sticky", FE_ERR, 1);
        do_reset();
        chk("err_cleared", FE_ERR, 0);
        req_rdy = 1;
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
